// File: rtl/reg_file_bank_pkg.sv
// Shared constants for the PIC16C5x register file: SFR addresses, write-command
// bit indices, STATUS bit positions and the address-region decoder.
package reg_file_bank_pkg;

  localparam logic [4:0] ADDR_INDF        = 5'h00;
  localparam logic [4:0] ADDR_TMR0        = 5'h01;
  localparam logic [4:0] ADDR_PCL         = 5'h02;
  localparam logic [4:0] ADDR_STATUS      = 5'h03;
  localparam logic [4:0] ADDR_FSR         = 5'h04;
  localparam logic [4:0] ADDR_PORTA       = 5'h05;
  localparam logic [4:0] ADDR_PORTB       = 5'h06;
  localparam logic [4:0] ADDR_PORTC       = 5'h07;
  localparam logic [4:0] ADDR_COMMON_BASE = 5'h08;
  localparam logic [4:0] ADDR_BANKED_BASE = 5'h10;

  localparam int unsigned WCMD_LATCH  = 2;
  localparam int unsigned WCMD_DATA   = 1;
  localparam int unsigned WCMD_STATUS = 0;

  localparam int unsigned STATUS_C   = 0;
  localparam int unsigned STATUS_DC  = 1;
  localparam int unsigned STATUS_Z   = 2;
  localparam int unsigned STATUS_PD  = 3;
  localparam int unsigned STATUS_TO  = 4;
  localparam int unsigned STATUS_PA0 = 5;
  localparam logic [7:0]  STATUS_RST = 8'h18;

  typedef enum logic [2:0] {
    RGN_INDF, RGN_TMR0, RGN_PCL, RGN_STATUS,
    RGN_FSR,  RGN_IO,   RGN_COMMON, RGN_BANKED
  } region_e;

  function automatic region_e decode_region(input logic [4:0] a);
    if (a >= ADDR_BANKED_BASE)      return RGN_BANKED;
    else if (a >= ADDR_COMMON_BASE) return RGN_COMMON;
    else if (a >= ADDR_PORTA)       return RGN_IO;
    else if (a == ADDR_FSR)         return RGN_FSR;
    else if (a == ADDR_STATUS)      return RGN_STATUS;
    else if (a == ADDR_PCL)         return RGN_PCL;
    else if (a == ADDR_TMR0)        return RGN_TMR0;
    else                            return RGN_INDF;
  endfunction

endpackage

// File: rtl/reg_file_bank_if.sv
// Bus between the GPR write-control stage / ALU (master) and the register file (slave).
interface reg_file_bank_if #(parameter int unsigned DATA_WIDTH = 8);
  logic [2:0]            writeCommand;
  logic [DATA_WIDTH-1:0] gprWriteDataIn;
  logic [DATA_WIDTH-1:0] statusWriteDataIn;
  logic                  instrCycleEnd;
  logic [DATA_WIDTH-1:0] pcLowIn;
  logic [DATA_WIDTH-1:0] ioReadDataIn;
  logic [DATA_WIDTH-1:0] gprReadDataOut;
  logic [DATA_WIDTH-1:0] gprStatusOut;
  logic [DATA_WIDTH-1:0] fsrOut;
  logic                  pclWriteEnOut;
  logic                  ioWriteEnOut;
  logic [1:0]            ioSelOut;
  logic [DATA_WIDTH-1:0] wrDataOut;

  modport master (
    output writeCommand, gprWriteDataIn, statusWriteDataIn, instrCycleEnd,
           pcLowIn, ioReadDataIn,
    input  gprReadDataOut, gprStatusOut, fsrOut, pclWriteEnOut, ioWriteEnOut,
           ioSelOut, wrDataOut
  );

  modport slave (
    input  writeCommand, gprWriteDataIn, statusWriteDataIn, instrCycleEnd,
           pcLowIn, ioReadDataIn,
    output gprReadDataOut, gprStatusOut, fsrOut, pclWriteEnOut, ioWriteEnOut,
           ioSelOut, wrDataOut
  );
endinterface

// File: rtl/reg_file_bank_tmr0_counter.sv
// TMR0: free-running instruction-cycle counter; a load suppresses the next two increments.
module tmr0_counter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] count_o
);
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [1:0]            inhibit_q, inhibit_d;

  always_comb begin
    count_d   = count_q;
    inhibit_d = inhibit_q;
    if (wr_en_i) begin
      count_d   = wr_data_i;
      inhibit_d = 2'd2;
    end else if (tick_i) begin
      if (inhibit_q != '0) inhibit_d = inhibit_q - 2'd1;
      else                 count_d   = count_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      inhibit_q <= '0;
    end else begin
      count_q   <= count_d;
      inhibit_q <= inhibit_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/reg_file_bank.sv
// PIC16C5x register file: Q2 address latch, INDF/FSR and bank resolution, Q4 commits.
// Optional TMR0 counter enabled by defining PIC_TMR0_EN.
module reg_file_bank
  import reg_file_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 4
) (
  input logic             clk,
  input logic             rst,
  reg_file_bank_if.slave  bus
);
  logic [4:0]            addr_q;
  logic [6:0]            fsr_q;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic [DATA_WIDTH-1:0] common_ram_q [8];
  logic [DATA_WIDTH-1:0] bank_ram_q   [NUM_BANKS*16];
  logic [DATA_WIDTH-1:0] tmr0_val;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [6:0]            eff;
  region_e               region;
  logic                  latch_en, data_we, status_we, data_to_status;
  logic                  unused_status_bits;

  assign latch_en  = bus.writeCommand[WCMD_LATCH]  && !rst;
  assign data_we   = bus.writeCommand[WCMD_DATA]   && !rst;
  assign status_we = bus.writeCommand[WCMD_STATUS] && !rst;

  assign eff    = (addr_q == ADDR_INDF) ? fsr_q : {fsr_q[6:5], addr_q};
  assign region = decode_region(eff[4:0]);
  assign data_to_status = data_we && (region == RGN_STATUS);

  // Data write owns PA bits, status write owns the flags; TO/PD never change.
  always_comb begin
    status_d = status_q;
    if (status_we) begin
      status_d[7:5] = bus.statusWriteDataIn[7:5];
      status_d[2:0] = bus.statusWriteDataIn[2:0];
    end
    if (data_to_status) begin
      status_d[7:5] = bus.gprWriteDataIn[7:5];
      if (!status_we) status_d[2:0] = bus.gprWriteDataIn[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      fsr_q    <= '0;
      status_q <= STATUS_RST;
    end else begin
      if (latch_en) addr_q <= bus.gprWriteDataIn[4:0];
      if (data_we && (region == RGN_FSR)) fsr_q <= bus.gprWriteDataIn[6:0];
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we && (region == RGN_COMMON)) common_ram_q[eff[2:0]] <= bus.gprWriteDataIn;
    if (data_we && (region == RGN_BANKED)) bank_ram_q[{eff[6:5], eff[3:0]}] <= bus.gprWriteDataIn;
  end

`ifdef PIC_TMR0_EN
  tmr0_counter #(.DATA_WIDTH(DATA_WIDTH)) u_tmr0 (
    .clk       (clk),
    .rst       (rst),
    .tick_i    (bus.instrCycleEnd),
    .wr_en_i   (data_we && (region == RGN_TMR0)),
    .wr_data_i (bus.gprWriteDataIn),
    .count_o   (tmr0_val)
  );
  assign unused_status_bits = ^bus.statusWriteDataIn[STATUS_TO:STATUS_PD];
`else
  assign tmr0_val = '0;
  assign unused_status_bits = ^{bus.statusWriteDataIn[STATUS_TO:STATUS_PD], bus.instrCycleEnd};
`endif

  always_comb begin
    rd_data = '0;
    case (region)
      RGN_TMR0:   rd_data = tmr0_val;
      RGN_PCL:    rd_data = bus.pcLowIn;
      RGN_STATUS: rd_data = status_q;
      RGN_FSR:    rd_data = {1'b1, fsr_q};
      RGN_IO:     rd_data = bus.ioReadDataIn;
      RGN_COMMON: rd_data = common_ram_q[eff[2:0]];
      RGN_BANKED: rd_data = bank_ram_q[{eff[6:5], eff[3:0]}];
      default:    rd_data = '0;
    endcase
  end

  assign bus.gprReadDataOut = rd_data;
  assign bus.gprStatusOut   = status_q;
  assign bus.fsrOut         = {1'b1, fsr_q};
  assign bus.pclWriteEnOut  = data_we && (region == RGN_PCL);
  assign bus.ioWriteEnOut   = data_we && (region == RGN_IO);
  assign bus.ioSelOut       = eff[1:0] - 2'd1;
  assign bus.wrDataOut      = bus.gprWriteDataIn;

  a_no_latch_with_write: assert property (@(posedge clk) disable iff (rst)
    !(bus.writeCommand[WCMD_LATCH] &&
      (bus.writeCommand[WCMD_DATA] || bus.writeCommand[WCMD_STATUS])));
endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench for reg_file_bank with a per-cycle reference model of the register map.
module tb_reg_file_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready = 1'b0;
  int   errors = 0;
  int   checks = 0;

  reg_file_bank_if #(.DATA_WIDTH(8)) bus ();

  reg_file_bank #(.DATA_WIDTH(8), .NUM_BANKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [4:0] m_addr;
  logic [6:0] m_fsr;
  logic [7:0] m_status;
  logic [7:0] m_tmr;
  int         m_inh;
  logic [7:0] m_ram [128];
  bit         m_vld [128];

  function automatic logic [6:0] m_eff();
    return (m_addr == 5'd0) ? m_fsr : {m_fsr[6:5], m_addr};
  endfunction

  // Common RAM is a single copy shared by all banks
  function automatic int ram_key(input logic [6:0] e);
    if (e[4:3] == 2'b01) return int'(e[4:0]);
    return int'(e);
  endfunction

  function automatic logic [7:0] nxt_status(input logic [7:0] old, input logic [7:0] gw,
                                            input logic [7:0] sw, input bit dw, input bit sww);
    logic [2:0] hi;
    logic [2:0] lo;
    hi = dw ? gw[7:5] : (sww ? sw[7:5] : old[7:5]);
    lo = sww ? sw[2:0] : (dw ? gw[2:0] : old[2:0]);
    return {hi, 2'b11, lo};
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_addr   <= 5'd0;
      m_fsr    <= 7'd0;
      m_status <= 8'h18;
      m_tmr    <= 8'd0;
      m_inh    <= 0;
    end else begin
      if (bus.writeCommand[2]) m_addr <= bus.gprWriteDataIn[4:0];
      if (bus.writeCommand[1]) begin
        if (m_eff() == m_eff() && m_eff()[4:0] == 5'h04) m_fsr <= bus.gprWriteDataIn[6:0];
        if (m_eff()[4:0] >= 5'h08) begin
          m_ram[ram_key(m_eff())] <= bus.gprWriteDataIn;
          m_vld[ram_key(m_eff())] <= 1'b1;
        end
      end
      m_status <= nxt_status(m_status, bus.gprWriteDataIn, bus.statusWriteDataIn,
                             bus.writeCommand[1] && (m_eff()[4:0] == 5'h03), bus.writeCommand[0]);
`ifdef PIC_TMR0_EN
      if (bus.writeCommand[1] && (m_eff()[4:0] == 5'h01)) begin
        m_tmr <= bus.gprWriteDataIn;
        m_inh <= 2;
      end else if (bus.instrCycleEnd) begin
        if (m_inh > 0) m_inh <= m_inh - 1;
        else           m_tmr <= m_tmr + 8'd1;
      end
`endif
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (ready && !rst) begin
      logic [6:0] e;
      logic [7:0] exp_rd;
      bit         known;
      e = m_eff();
      known = 1'b1;
      case (e[4:0])
        5'h00: exp_rd = 8'h00;
`ifdef PIC_TMR0_EN
        5'h01: exp_rd = m_tmr;
`else
        5'h01: exp_rd = 8'h00;
`endif
        5'h02: exp_rd = bus.pcLowIn;
        5'h03: exp_rd = m_status;
        5'h04: exp_rd = {1'b1, m_fsr};
        5'h05, 5'h06, 5'h07: exp_rd = bus.ioReadDataIn;
        default: begin
          exp_rd = m_ram[ram_key(e)];
          known  = m_vld[ram_key(e)];
        end
      endcase
      if (known) check("rd", bus.gprReadDataOut, exp_rd);
      check("status", bus.gprStatusOut, m_status);
      check("fsr", bus.fsrOut, {1'b1, m_fsr});
      check("pclWe", {7'd0, bus.pclWriteEnOut}, {7'd0, bus.writeCommand[1] && (e[4:0] == 5'h02)});
      check("ioWe", {7'd0, bus.ioWriteEnOut},
            {7'd0, bus.writeCommand[1] && (e[4:0] >= 5'h05) && (e[4:0] <= 5'h07)});
      check("wrData", bus.wrDataOut, bus.gprWriteDataIn);
      if (e[4:0] >= 5'h05 && e[4:0] <= 5'h07)
        check("ioSel", {6'd0, bus.ioSelOut}, {6'd0, 2'(int'(e[4:0]) - 5)});
    end
  end

  task automatic idle();
    bus.writeCommand      = 3'b000;
    bus.instrCycleEnd     = 1'b0;
  endtask

  task automatic cmd(input logic [2:0] wc, input logic [7:0] gw, input logic [7:0] sw,
                     input logic ice);
    bus.writeCommand      = wc;
    bus.gprWriteDataIn    = gw;
    bus.statusWriteDataIn = sw;
    bus.instrCycleEnd     = ice;
    @(posedge clk);
    #1 idle();
    #1;
  endtask

  task automatic latch(input logic [4:0] a);
    cmd(3'b100, {3'b000, a}, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [7:0] d);
    cmd(3'b010, d, 8'h00, 1'b0);
  endtask

  initial begin
    idle();
    bus.gprWriteDataIn    = 8'h00;
    bus.statusWriteDataIn = 8'h00;
    bus.pcLowIn           = 8'h3C;
    bus.ioReadDataIn      = 8'hC3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ready = 1'b1;
    #1;
    check("rst_status", bus.gprStatusOut, 8'h18);
    check("rst_fsr", bus.fsrOut, 8'h80);
    check("rst_rd", bus.gprReadDataOut, 8'h00);
    check("rst_pclWe", {7'd0, bus.pclWriteEnOut}, 8'h00);

    latch(5'h03); check("rd_status", bus.gprReadDataOut, 8'h18);
    latch(5'h04); check("rd_fsr", bus.gprReadDataOut, 8'h80);
    wr(8'h35);    check("fsr_b5", bus.fsrOut, 8'hB5);

    latch(5'h00); wr(8'hA5); check("indf_rd", bus.gprReadDataOut, 8'hA5);
    latch(5'h15); check("bank1_direct", bus.gprReadDataOut, 8'hA5);
    latch(5'h04); wr(8'h15);
    latch(5'h15); wr(8'h11); check("bank0_direct", bus.gprReadDataOut, 8'h11);
    latch(5'h04); wr(8'h35);
    latch(5'h15); check("bank1_again", bus.gprReadDataOut, 8'hA5);

    latch(5'h04); wr(8'h00);
    latch(5'h0A); wr(8'h5A);
    latch(5'h04); wr(8'h60);
    latch(5'h0A); check("common_alias", bus.gprReadDataOut, 8'h5A);

    latch(5'h03);
    cmd(3'b011, 8'hE0, 8'h07, 1'b0); check("status_both", bus.gprStatusOut, 8'hFF);
    cmd(3'b001, 8'h00, 8'h00, 1'b0); check("status_sw", bus.gprStatusOut, 8'h18);
    wr(8'h27);                       check("status_dw", bus.gprStatusOut, 8'h3F);

    latch(5'h01);
    wr(8'hFE);
`ifdef PIC_TMR0_EN
    check("tmr_load", bus.gprReadDataOut, 8'hFE);
    cmd(3'b000, 8'h00, 8'h00, 1'b1); check("tmr_inh1", bus.gprReadDataOut, 8'hFE);
    cmd(3'b000, 8'h00, 8'h00, 1'b1); check("tmr_inh2", bus.gprReadDataOut, 8'hFE);
    cmd(3'b000, 8'h00, 8'h00, 1'b1); check("tmr_inc", bus.gprReadDataOut, 8'hFF);
    cmd(3'b000, 8'h00, 8'h00, 1'b1); check("tmr_wrap", bus.gprReadDataOut, 8'h00);
    cmd(3'b010, 8'h80, 8'h00, 1'b1); check("tmr_wr_wins", bus.gprReadDataOut, 8'h80);
`else
    check("tmr_off", bus.gprReadDataOut, 8'h00);
    repeat (3) cmd(3'b000, 8'h00, 8'h00, 1'b1);
    check("tmr_off_tick", bus.gprReadDataOut, 8'h00);
`endif

    latch(5'h02); check("pcl_rd", bus.gprReadDataOut, 8'h3C);
    bus.writeCommand   = 3'b010;
    bus.gprWriteDataIn = 8'h40;
    #1;
    check("pcl_we", {7'd0, bus.pclWriteEnOut}, 8'h01);
    check("pcl_wrdata", bus.wrDataOut, 8'h40);
    check("pcl_io_we", {7'd0, bus.ioWriteEnOut}, 8'h00);
    @(posedge clk);
    #1 idle();
    #1 check("pcl_we_off", {7'd0, bus.pclWriteEnOut}, 8'h00);

    bus.ioReadDataIn = 8'h5E;
    latch(5'h06);
    check("io_sel", {6'd0, bus.ioSelOut}, 8'h01);
    check("io_rd", bus.gprReadDataOut, 8'h5E);
    bus.writeCommand   = 3'b010;
    bus.gprWriteDataIn = 8'h77;
    #1 check("io_we", {7'd0, bus.ioWriteEnOut}, 8'h01);
    @(posedge clk);
    #1 idle();
    #1;
    latch(5'h07); check("io_sel_c", {6'd0, bus.ioSelOut}, 8'h02);
    latch(5'h05); check("io_sel_a", {6'd0, bus.ioSelOut}, 8'h00);

    latch(5'h04); wr(8'h20);
    latch(5'h00); check("indf_self", bus.gprReadDataOut, 8'h00);
    wr(8'h99);    check("indf_noop", bus.gprReadDataOut, 8'h00);
    check("indf_fsr_kept", bus.fsrOut, 8'hA0);

    latch(5'h03);
    rst = 1'b1;
    bus.writeCommand   = 3'b100;
    bus.gprWriteDataIn = 8'h0A;
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    #1;
    check("midrst_rd", bus.gprReadDataOut, 8'h00);
    check("midrst_fsr", bus.fsrOut, 8'h80);
    check("midrst_status", bus.gprStatusOut, 8'h18);
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
